// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_debounce_pkg : shared types and helpers for sync_debounce        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package sync_debounce_pkg;

  // Transition a filter channel will commit on the coming clock edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Stability counter width: max(1, clog2(filter_cycles)).
  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_channel : one-bit glitch filter with rise/fall pulses        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic INIT_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s,
  output logic out,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int               CNT_W   = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  edge_e            evt;

  // A new level is committed on the edge where the mismatch has already
  // been seen FILTER_CYCLES-1 times and is still present.
  always_comb begin
    evt = EDGE_NONE;
    if ((s != out) && (cnt == CNT_MAX)) begin
      evt = s ? EDGE_RISE : EDGE_FALL;
    end
  end

  assign accept = (evt != EDGE_NONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out  <= INIT_VALUE;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (evt == EDGE_RISE);
      fall <= (evt == EDGE_FALL);
      if (s == out) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        out <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_debounce : multi-channel synchronizer + glitch filter            |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if ((WIDTH < 1) || (FILTER_CYCLES < 1)) begin : g_param_check
    $error("sync_debounce: WIDTH and FILTER_CYCLES must both be >= 1");
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] accept;

  if (STAGES == 0) begin : g_no_sync
    assign s = in;
  end else begin : g_sync
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) begin
          chain[i] <= INIT_VALUE;
        end
      end else begin
        chain[0] <= in;
        for (int i = 1; i < STAGES; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign s = chain[STAGES-1];
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .INIT_VALUE    (INIT_VALUE[g])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (s[g]),
      .out     (out[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .accept  (accept[g])
    );
  end

  // Registered from the same next-edge decision as rise/fall, so it lines up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_debounce : scoreboard bench for sync_debounce                 |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sync_debounce;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, b_rst_n;
  logic [3:0] a_in, a_out, a_rise, a_fall;
  logic [3:0] b_in, b_out, b_rise, b_fall;
  logic       a_changed, b_changed;

  sync_debounce #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .INIT_VALUE(4'h0)
  ) dut_a (
    .clk(clk), .reset_n(a_rst_n), .in(a_in), .out(a_out),
    .rise(a_rise), .fall(a_fall), .changed(a_changed)
  );

  sync_debounce #(
    .WIDTH(4), .STAGES(0), .FILTER_CYCLES(1), .INIT_VALUE(4'hF)
  ) dut_b (
    .clk(clk), .reset_n(b_rst_n), .in(b_in), .out(b_out),
    .rise(b_rise), .fall(b_fall), .changed(b_changed)
  );

  typedef struct packed {
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;
  } step_t;

  step_t sb[$];
  int    tests_run = 0;
  int    failed    = 0;

  // Stimulus for one cycle plus the outputs expected right after that edge.
  function automatic void push(input logic rst_n, input logic [3:0] in_v,
                               input logic [3:0] out_v, input logic [3:0] rise_v,
                               input logic [3:0] fall_v);
    step_t e;
    e.rst_n   = rst_n;
    e.in      = in_v;
    e.out     = out_v;
    e.rise    = rise_v;
    e.fall    = fall_v;
    e.changed = |{rise_v, fall_v};
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 7; i++) push(i >= 3, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL reset step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  task automatic test_rise();
    for (int i = 0; i < 12; i++)
      push(1'b1, (i < 6) ? 4'h1 : 4'h0, (i >= 4 && i < 10) ? 4'h1 : 4'h0,
           (i == 4) ? 4'h1 : 4'h0, (i == 10) ? 4'h1 : 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL rise step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) push(1'b1, (i < 2) ? 4'h2 : 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++)
      push(1'b1, (i < 3) ? 4'h2 : 4'h0, (i >= 4 && i < 7) ? 4'h2 : 4'h0,
           (i == 4) ? 4'h2 : 4'h0, (i == 7) ? 4'h2 : 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL glitch step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 13; i++)
      push(1'b1, (i < 6) ? 4'hA : 4'h0, (i >= 4 && i < 10) ? 4'hA : 4'h0,
           (i == 4) ? 4'hA : 4'h0, (i == 10) ? 4'hA : 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL simultaneous step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  // Runs of exactly FilterCycles: output is the input delayed by 4 edges,
  // with one pulse per accepted transition.
  task automatic test_back_to_back();
    logic [3:0] stim [24];
    logic [3:0] exp_out, prev_out;
    for (int i = 0; i < 24; i++) stim[i] = ((i % 6) < 3 && i < 18) ? 4'h8 : 4'h0;
    prev_out = 4'h0;
    for (int i = 0; i < 24; i++) begin
      exp_out = (i >= 4) ? stim[i-4] : 4'h0;
      push(1'b1, stim[i], exp_out, exp_out & ~prev_out, ~exp_out & prev_out);
      prev_out = exp_out;
    end
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL back_to_back step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    for (int i = 0; i < 20; i++)
      push(!(i == 4 || i == 5), (i < 13) ? 4'h4 : 4'h0,
           (i >= 10 && i < 17) ? 4'h4 : 4'h0,
           (i == 10) ? 4'h4 : 4'h0, (i == 17) ? 4'h4 : 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      a_rst_n = e.rst_n; a_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({a_out, a_rise, a_fall, a_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL reset_mid_count step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, a_out, a_rise, a_fall, a_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
  endtask

  task automatic test_bypass();
    push(1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    push(1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    push(1'b1, 4'h0, 4'h0, 4'h0, 4'hF);
    push(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    push(1'b1, 4'h5, 4'h5, 4'h5, 4'h0);
    push(1'b1, 4'h5, 4'h5, 4'h0, 4'h0);
    push(1'b1, 4'h0, 4'h0, 4'h0, 4'h5);
    push(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; sb.size() > 0; i++) begin
      step_t e = sb.pop_front();
      b_rst_n = e.rst_n; b_in = e.in;
      @(posedge clk); #1;
      tests_run++;
      if ({b_out, b_rise, b_fall, b_changed} !== {e.out, e.rise, e.fall, e.changed}) begin
        failed++;
        $display("FAIL bypass step %0d: got out=%b rise=%b fall=%b chg=%b, want out=%b rise=%b fall=%b chg=%b",
                 i, b_out, b_rise, b_fall, b_changed, e.out, e.rise, e.fall, e.changed);
      end
    end
    // Reset must take effect without waiting for a clock edge.
    b_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({b_out, b_rise, b_fall, b_changed} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      failed++;
      $display("FAIL bypass async_reset: got out=%b rise=%b fall=%b chg=%b, want out=1111 rise=0000 fall=0000 chg=0",
               b_out, b_rise, b_fall, b_changed);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in    = 4'h0; b_in    = 4'h0;
    test_reset();
    test_rise();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_count();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire
